// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops one word from a TX FIFO and serialises it as start/data/[parity]/stop.
// Optional even-parity bit is built in when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl #(
  parameter int W_DATA       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [W_DATA-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  // state   | meaning
  // IDLE    | line idle high, waiting for FIFO data
  // FETCH   | pop request to FIFO
  // LOAD    | FIFO data valid, capture into shift register
  // START   | start bit (low)
  // DATA    | data bits, LSB first
  // PARITY  | even parity bit (parity build only)
  // STOP    | stop bit(s), high
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam int BAUD_W = $clog2(CLKS_PER_BIT * STOP_BITS);
  localparam int BIT_W  = $clog2(W_DATA);

  localparam logic [BAUD_W-1:0] BIT_TC   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_TC  = BAUD_W'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(W_DATA - 1);

  state_t              state_q, state_d;
  logic [W_DATA-1:0]   shift_q, shift_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d  = fifo_rd_data;
        baud_d   = '0;
        bit_d    = '0;
`ifdef UART_TX_PARITY_EN
        parity_d = ^fifo_rd_data;
`endif
        state_d  = START;
      end
      START: begin
        if (baud_q == BIT_TC) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == BIT_TC) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_q == BIT_TC) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_q == STOP_TC) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level is derived from the next state so tx and state flip on the same edge.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign tx         = tx_q;
  assign fifo_rd_en = (state_q == FETCH);
  assign busy       = (state_q != IDLE);
  assign tx_done    = (state_q == STOP) && (baud_q == STOP_TC);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frame shape, inter-frame gap, idle quietness, reset behaviour.
// A second instance with two stop bits covers the long-stop case.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int SPB = 4;

  logic       clk;
  logic       rst_n;
  logic       fifo_empty, fifo_rd_en, tx, busy, tx_done;
  logic [7:0] fifo_rd_data;
  logic       fifo_empty2, fifo_rd_en2, tx2, busy2, tx_done2;
  logic [7:0] fifo_rd_data2;

  logic [7:0] mem [16];
  int wr_ptr = 0, rd_ptr = 0;
  int wr2 = 0, rd2 = 0;
  logic [7:0] data2;

  int n_checks = 0, n_fail = 0;
  int rd_cnt = 0, done_cnt = 0;
  int last_gap;

  uart_tx_ctrl #(.W_DATA(8), .CLKS_PER_BIT(SPB), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  uart_tx_ctrl #(.W_DATA(8), .CLKS_PER_BIT(SPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty2), .fifo_rd_data(fifo_rd_data2),
    .fifo_rd_en(fifo_rd_en2), .tx(tx2), .busy(busy2), .tx_done(tx_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO models: read data appears the cycle after the pop request
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_empty2 = (wr2 == rd2);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[rd_ptr % 16];
      rd_ptr       <= rd_ptr + 1;
    end
    if (fifo_rd_en2 && !fifo_empty2) begin
      fifo_rd_data2 <= data2;
      rd2           <= rd2 + 1;
    end
  end

  always @(negedge clk) begin
    if (fifo_rd_en) rd_cnt++;
    if (tx_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 16] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic logic cur_tx(input int sel);
    return (sel != 0) ? tx2 : tx;
  endfunction

  function automatic logic cur_done(input int sel);
    return (sel != 0) ? tx_done2 : tx_done;
  endfunction

  // Counts idle-high cycles until the start bit is seen; leaves us on its first cycle.
  task automatic wait_start(input int sel, input string tag, output int n);
    n = 0;
    while (cur_tx(sel) !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({tag, "_start_timeout"}, 1, 0);
  endtask

  task automatic recv_frame(input int sel, input logic [7:0] data, input logic par,
                            input int stop_cyc, input string tag);
    logic [9:0] exp_bits;
    logic [3:0] samp;
    int         n, bad, done_ok;
    exp_bits = {par, data, 1'b0};
    wait_start(sel, tag, n);
    last_gap = n;
    for (int i = 0; i < 9 + PAR; i++) begin
      for (int c = 0; c < SPB; c++) begin
        samp[c] = cur_tx(sel);
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d", tag, i), samp, {4{exp_bits[i]}});
    end
    bad = 0;
    done_ok = 0;
    for (int c = 0; c < stop_cyc; c++) begin
      if (cur_tx(sel) !== 1'b1) bad++;
      if (cur_done(sel) === 1'b1) begin
        if (c == stop_cyc - 1) done_ok = 1;
        else bad++;
      end
      @(negedge clk);
    end
    check({tag, "_stop_high"}, bad, 0);
    check({tag, "_done_last"}, done_ok, 1);
  endtask

  initial begin
    int rd0, dn0, bad, n;
    rst_n = 1'b0;
    data2 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_rden", fifo_rd_en, 0);
    check("rst_done", tx_done, 0);
    check("rst_tx2", tx2, 1);
    rst_n = 1'b1;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);

    rd0 = rd_cnt; dn0 = done_cnt;
    push(8'hA5);
    recv_frame(0, 8'hA5, 1'b0, SPB, "a5");
    check("a5_rden_cnt", rd_cnt - rd0, 1);
    check("a5_done_cnt", done_cnt - dn0, 1);
    check("a5_idle_busy", busy, 0);

    push(8'h0F);
    recv_frame(0, 8'h0F, 1'b0, SPB, "0f");

    push(8'h07);
    recv_frame(0, 8'h07, 1'b1, SPB, "07");

    rd0 = rd_cnt; dn0 = done_cnt;
    push(8'h55);
    push(8'hAA);
    recv_frame(0, 8'h55, 1'b0, SPB, "55");
    recv_frame(0, 8'hAA, 1'b0, SPB, "aa");
    check("gap_cycles", last_gap, 3);
    check("pair_rden_cnt", rd_cnt - rd0, 2);
    check("pair_done_cnt", done_cnt - dn0, 2);

    // reset while in data bit 3
    push(8'h0F);
    wait_start(0, "rst_mid", n);
    repeat (SPB + 3 * SPB + 1) @(negedge clk);
    check("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd0 = rd_cnt;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("post_rst_quiet", bad, 0);
    check("post_rst_rden", rd_cnt - rd0, 0);

    // two stop bits
    data2 = 8'h00;
    wr2 = wr2 + 1;
    recv_frame(1, 8'h00, 1'b0, 2 * SPB, "sb2");
    check("sb2_busy_after", busy2, 0);

    // first pop after reset release
    rst_n = 1'b0;
    push(8'h3C);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rden_at_release", fifo_rd_en, 0);
    @(negedge clk);
    check("rden_second_edge", fifo_rd_en, 1);
    recv_frame(0, 8'h3C, 1'b0, SPB, "3c");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
